// File: rtl/lvg_drain_if.sv
// Result-stream interface between lvg_drain and its consumer (DMA, host FIFO, UART bridge).
// Valid/ready: a beat moves on a clock edge where out_valid && out_ready; once raised, out_valid and the payload
// (out_data, out_row, out_col, out_last) hold unchanged until that transfer happens.
interface lvg_drain_if #(
    parameter int DATA_W = 32,
    parameter int N      = 4
);
    localparam int RC_W = (N > 1) ? $clog2(N) : 1;

    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic [RC_W-1:0]   out_row;
    logic [RC_W-1:0]   out_col;

    modport master (
        output out_data, out_valid, out_last, out_row, out_col,
        input  out_ready
    );

    modport slave (
        input  out_data, out_valid, out_last, out_row, out_col,
        output out_ready
    );
endinterface

// File: rtl/lvg_drain.sv
// lvg_drain: snapshots the lvg engine's N*N result matrix and streams it out one word per beat.
// Define LVG_DRAIN_COL_MAJOR_EN for column-major beat order; default build streams row-major.
module lvg_drain #(
    parameter  int DATA_W = 32,
    parameter  int N      = 4,
    localparam int CNT    = N * N,
    localparam int IDX_W  = (CNT > 1) ? $clog2(CNT) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  capture,
    input  logic [CNT*DATA_W-1:0] res_flat,
    lvg_drain_if.master           o,
    output logic                  busy,
    output logic                  overrun,
    output logic                  dbg_state,
    output logic [IDX_W-1:0]      dbg_idx
);
    localparam int              RC_W     = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CNT - 1);
    localparam logic [IDX_W-1:0] N_IDX    = IDX_W'(N);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] buf_q [CNT];
    logic [DATA_W-1:0] buf_d [CNT];
    logic              overrun_q, overrun_d;

    logic              streaming;
    logic              fire;
    logic              load;
    logic [RC_W-1:0]   row_w;
    logic [RC_W-1:0]   col_w;
    logic [IDX_W-1:0]  elem_w;

    // Beat index -> element position; the buffer stays in res_flat (row-major) order in both builds.
    always_comb begin
        row_w = '0;
        col_w = '0;
`ifdef LVG_DRAIN_COL_MAJOR_EN
        row_w = RC_W'(idx_q % N_IDX);
        col_w = RC_W'(idx_q / N_IDX);
`else
        row_w = RC_W'(idx_q / N_IDX);
        col_w = RC_W'(idx_q % N_IDX);
`endif
        elem_w = IDX_W'(row_w) * N_IDX + IDX_W'(col_w);
    end

    // Outputs decode registered state only, so nothing combinational leaks from out_ready or capture.
    always_comb begin
        streaming   = (state_q == STREAM);
        o.out_valid = streaming;
        o.out_data  = '0;
        o.out_row   = '0;
        o.out_col   = '0;
        o.out_last  = 1'b0;
        if (streaming) begin
            o.out_data = buf_q[elem_w];
            o.out_row  = row_w;
            o.out_col  = col_w;
            o.out_last = (idx_q == LAST_IDX);
        end
        busy      = streaming;
        overrun   = overrun_q;
        dbg_state = (state_q == STREAM);
        dbg_idx   = idx_q;
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        buf_d     = buf_q;
        overrun_d = overrun_q;
        load      = 1'b0;
        fire      = streaming && o.out_ready;

        case (state_q)
            IDLE: begin
                if (capture) begin
                    load    = 1'b1;
                    idx_d   = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (fire && (idx_q == LAST_IDX)) begin
                    // A capture landing on the final transfer chains the next matrix with no bubble.
                    idx_d = '0;
                    if (capture) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (fire) begin
                        idx_d = idx_q + 1'b1;
                    end
                    if (capture) begin
                        overrun_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase

        if (load) begin
            for (int k = 0; k < CNT; k++) begin
                buf_d[k] = res_flat[k*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            overrun_q <= 1'b0;
            for (int k = 0; k < CNT; k++) begin
                buf_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            overrun_q <= overrun_d;
            buf_q     <= buf_d;
        end
    end
endmodule

// File: tb/tb_lvg_drain.sv
// Self-checking bench for lvg_drain: expected beats come from a queue built from the loaded matrix.
module tb_lvg_drain;
    localparam int DATA_W = 32;
    localparam int N      = 4;
    localparam int CNT    = N * N;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  capture;
    logic [CNT*DATA_W-1:0] res_flat;
    logic                  busy;
    logic                  overrun;
    logic                  dbg_state;
    logic [3:0]            dbg_idx;

    lvg_drain_if #(.DATA_W(DATA_W), .N(N)) dif ();

    lvg_drain #(.DATA_W(DATA_W), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .capture   (capture),
        .res_flat  (res_flat),
        .o         (dif.master),
        .busy      (busy),
        .overrun   (overrun),
        .dbg_state (dbg_state),
        .dbg_idx   (dbg_idx)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] mat [CNT];
    logic [36:0] exp_q [$];   // {last, row, col, data}

    function automatic logic [CNT*DATA_W-1:0] pack_mat();
        logic [CNT*DATA_W-1:0] v;
        v = '0;
        for (int k = 0; k < CNT; k++) v[k*DATA_W +: DATA_W] = mat[k];
        return v;
    endfunction

    // Reference order: beat b visits element (b/N, b%N), or (b%N, b/N) in the column-major build.
    function automatic void model_push();
        for (int b = 0; b < CNT; b++) begin
            int i;
            int j;
`ifdef LVG_DRAIN_COL_MAJOR_EN
            i = b % N;
            j = b / N;
`else
            i = b / N;
            j = b % N;
`endif
            exp_q.push_back({(b == CNT - 1), 2'(i), 2'(j), mat[i*N+j]});
        end
    endfunction

    function automatic logic [37:0] observed();
        return {dif.out_valid, dif.out_last, dif.out_row, dif.out_col, dif.out_data};
    endfunction

    function automatic logic [37:0] expected_beat();
        if (exp_q.size() == 0) return '0;
        return {1'b1, exp_q[0]};
    endfunction

    task automatic fill_seq();
        for (int k = 0; k < CNT; k++) mat[k] = 32'h3f800000 + 32'(k);
    endtask

    task automatic fill_rand();
        for (int k = 0; k < CNT; k++) mat[k] = $urandom;
    endtask

    // Called at a negedge; returns at the negedge where the first beat should be on the bus.
    task automatic start_capture();
        res_flat = pack_mat();
        capture  = 1'b1;
        model_push();
        @(negedge clk);
        capture = 1'b0;
    endtask

    task automatic reset_dut(input int cycles);
        @(negedge clk);
        rst     = 1'b1;
        capture = 1'b0;
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset_dut(2);
        checks++;
        if ({observed(), busy, overrun} !== 40'h0) begin
            failures++;
            $display("FAIL reset_outputs: got %h want %h", {observed(), busy, overrun}, 40'h0);
        end
        checks++;
        if ({dbg_state, dbg_idx} !== 5'h0) begin
            failures++;
            $display("FAIL reset_state: got %h want %h", {dbg_state, dbg_idx}, 5'h0);
        end
    endtask

    task automatic test_row_major();
        logic [37:0] got;
        logic [37:0] want;
        reset_dut(1);
        fill_seq();
        dif.out_ready = 1'b1;
        start_capture();
        for (int b = 0; b < CNT; b++) begin
            got  = observed();
            want = expected_beat();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL stream beat=%0d: got %h want %h", b, got, want);
            end
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            @(negedge clk);
        end
        checks++;
        if ({dif.out_valid, busy, overrun} !== 3'b000) begin
            failures++;
            $display("FAIL stream_end: got %b want %b", {dif.out_valid, busy, overrun}, 3'b000);
        end
    endtask

    // mode 0: fixed 1,0,0 ready pattern on the sequential load; mode 1: random ready on random data.
    task automatic test_backpressure(input int mode);
        logic [37:0] got;
        logic [37:0] want;
        logic [37:0] prev;
        logic        stalled;
        int          xfers;
        int          cyc;
        reset_dut(1);
        if (mode == 0) fill_seq();
        else fill_rand();
        start_capture();
        stalled = 1'b0;
        prev    = '0;
        xfers   = 0;
        cyc     = 0;
        while (xfers < CNT && cyc < 300) begin
            if (mode == 0) dif.out_ready = (cyc % 3 == 0);
            else dif.out_ready = 1'($urandom_range(0, 1));
            got = observed();
            if (stalled) begin
                checks++;
                if (got !== prev) begin
                    failures++;
                    $display("FAIL stall_hold cyc=%0d: got %h want %h", cyc, got, prev);
                end
            end
            if (dif.out_valid && dif.out_ready) begin
                want = expected_beat();
                checks++;
                if (got !== want) begin
                    failures++;
                    $display("FAIL bp_beat xfer=%0d: got %h want %h", xfers, got, want);
                end
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                xfers++;
            end
            stalled = dif.out_valid && !dif.out_ready;
            prev    = got;
            cyc++;
            @(negedge clk);
        end
        dif.out_ready = 1'b1;
        checks++;
        if ({xfers, dif.out_valid} !== {CNT, 1'b0}) begin
            failures++;
            $display("FAIL bp_total: got xfers=%0d valid=%b want xfers=%0d valid=0", xfers, dif.out_valid, CNT);
        end
    endtask

    task automatic test_overrun();
        logic [37:0] got;
        logic [37:0] want;
        reset_dut(1);
        fill_rand();
        dif.out_ready = 1'b1;
        start_capture();
        for (int b = 0; b < CNT; b++) begin
            got  = observed();
            want = expected_beat();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL overrun_beat beat=%0d: got %h want %h", b, got, want);
            end
            if (b >= 6) begin
                checks++;
                if (overrun !== 1'b1) begin
                    failures++;
                    $display("FAIL overrun_flag beat=%0d: got %b want 1", b, overrun);
                end
            end
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            if (b == 5) begin
                res_flat = {CNT{32'h40000000}};
                capture  = 1'b1;
            end else begin
                capture = 1'b0;
            end
            @(negedge clk);
        end
        capture = 1'b0;
        checks++;
        if ({dif.out_valid, overrun} !== 2'b01) begin
            failures++;
            $display("FAIL overrun_end: got %b want %b", {dif.out_valid, overrun}, 2'b01);
        end
    endtask

    task automatic test_back_to_back();
        logic [37:0] got;
        logic [37:0] want;
        reset_dut(1);
        fill_rand();
        dif.out_ready = 1'b1;
        start_capture();
        for (int b = 0; b < 2 * CNT; b++) begin
            got  = observed();
            want = expected_beat();
            checks++;
            if ({got, overrun} !== {want, 1'b0}) begin
                failures++;
                $display("FAIL b2b_beat beat=%0d: got %h ovr=%b want %h ovr=0", b, got, overrun, want);
            end
            if (b == CNT) begin
                checks++;
                if ({dif.out_data, dif.out_row, dif.out_col} !== {32'h3e9cdd17, 2'd0, 2'd0}) begin
                    failures++;
                    $display("FAIL b2b_first: got %h r%0d c%0d want 3e9cdd17 r0 c0",
                             dif.out_data, dif.out_row, dif.out_col);
                end
            end
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            if (b == CNT - 1) begin
                for (int k = 0; k < CNT; k++) mat[k] = 32'h0;
                mat[0]   = 32'h3e9cdd17;
                mat[N]   = 32'h3ee3e433;
                res_flat = pack_mat();
                capture  = 1'b1;
                model_push();
            end else begin
                capture = 1'b0;
            end
            @(negedge clk);
        end
        capture = 1'b0;
        checks++;
        if ({dif.out_valid, busy} !== 2'b00) begin
            failures++;
            $display("FAIL b2b_end: got %b want %b", {dif.out_valid, busy}, 2'b00);
        end
    endtask

    task automatic test_reset_mid();
        logic [37:0] got;
        logic [37:0] want;
        reset_dut(1);
        fill_rand();
        dif.out_ready = 1'b1;
        start_capture();
        for (int b = 0; b <= 7; b++) begin
            got  = observed();
            want = expected_beat();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL mid_beat beat=%0d: got %h want %h", b, got, want);
            end
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            if (b == 7) begin
                rst = 1'b1;
                res_flat = {CNT{32'h40000000}};
                capture  = 1'b1;
            end
            @(negedge clk);
        end
        rst     = 1'b0;
        capture = 1'b0;
        exp_q.delete();
        checks++;
        if ({dif.out_valid, busy, overrun, dbg_state, dbg_idx} !== 8'h00) begin
            failures++;
            $display("FAIL mid_reset: got %h want 00", {dif.out_valid, busy, overrun, dbg_state, dbg_idx});
        end
        fill_rand();
        start_capture();
        for (int b = 0; b < CNT; b++) begin
            got  = observed();
            want = expected_beat();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL mid_restart beat=%0d: got %h want %h", b, got, want);
            end
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            @(negedge clk);
        end
        checks++;
        if (dif.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_restart_end: got %b want 0", dif.out_valid);
        end
    endtask

    initial begin
        rst           = 1'b1;
        capture       = 1'b0;
        res_flat      = '0;
        dif.out_ready = 1'b0;
        test_reset();
        test_row_major();
        test_backpressure(0);
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        for (int r = 0; r < 4; r++) test_backpressure(1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end
endmodule

// File: doc/lvg_drain.md
Name: lvg_drain

Overview:
- Result-side reader for the lvg 4x4 FP32 matrix engine.
- Captures the full N×N result matrix (r11..r44) in one cycle when the engine signals completion.
- Streams the words out one per beat over a valid/ready interface to downstream logic (DMA, host FIFO, UART bridge).
- Decouples the engine from a slow consumer, so the engine can start the next load while the drain empties.

Parameters:
DATA_W, 32, width of one matrix element (IEEE-754 single).
N, 4, matrix dimension; N*N words per matrix.

Ports:
clk  in  1  clock; all logic on posedge.
rst  in  1  synchronous, active-high reset.
capture  in  1  single-cycle strobe: res_flat holds a complete valid result this cycle.
res_flat  in  N*N*DATA_W  flattened result. Element (i,j), 0-based row i and column j, sits at bits [(i*N+j+1)*DATA_W-1 : (i*N+j)*DATA_W]. r11 is at [31:0]; r44 is at the top.
out_data  out  DATA_W  current element.
out_valid  out  1  out_data is valid.
out_ready  in  1  consumer accepts a beat when out_valid && out_ready.
out_last  out  1  high with the final element of a matrix.
out_row  out  $clog2(N)  row index of out_data.
out_col  out  $clog2(N)  column index of out_data.
busy  out  1  high while in STREAM.
overrun  out  1  sticky: a capture was dropped. Cleared only by rst.

Behaviour:
- State machine with two states, IDLE and STREAM. Reset state is IDLE.
- Reset values: out_valid=0, out_last=0, out_data=0, out_row=0, out_col=0, busy=0, overrun=0. Internal buffer cleared to 0; beat index idx=0.
- rst has priority over every other input. rst asserted mid-stream aborts the matrix immediately; no further beats are issued.
- IDLE:
  - capture=1 latches all N*N words into the internal buffer, sets idx=0, and moves to STREAM.
  - Latency: capture at edge t gives out_valid=1 after edge t+1, presenting element (0,0).
- STREAM:
  - out_valid=1 and busy=1 throughout.
  - out_data = buf[idx]; out_row and out_col decode idx; out_last = (idx == N*N-1).
  - All outputs are registered or decoded from registered state only. They depend combinationally on nothing but registers.
- Handshake rules:
  - A beat transfers when out_valid && out_ready.
  - While out_ready=0, out_data, out_row, out_col and out_last hold stable and out_valid stays high. Valid is never withdrawn without a transfer.
  - On a transfer with idx < N*N-1: idx increments by 1.
  - On a transfer with idx = N*N-1 and capture=0: go to IDLE; out_valid=0 on the next cycle.
- Order is row-major: (0,0),(0,1),…,(0,N-1),(1,0),…,(N-1,N-1). Exactly N*N beats per capture.
- Simultaneous events:
  - capture in STREAM not coinciding with the final transfer: dropped. overrun sets to 1; the buffer is unchanged and streaming continues.
  - capture in the same cycle as the final transfer: accepted. Buffer reloads, idx=0, state stays STREAM, overrun unaffected. The next matrix starts with no bubble.
  - capture and rst together: rst wins; nothing is latched.
- Throughput: with out_ready tied high, one beat per cycle. A matrix occupies N*N consecutive cycles.

Optional Feature:
Macro LVG_DRAIN_COL_MAJOR_EN.
- Defined: stream in column-major order: (0,0),(1,0),…,(N-1,0),(0,1),…,(N-1,N-1). out_row and out_col still report the true element position. out_last stays on beat N*N-1, i.e. element (N-1,N-1).
- Not defined: row-major only, as described in Behaviour.
- Handshake, latency and overrun behaviour are identical in both builds.

Test Plan:
- Row-major stream:
  - Stimulus: reset 2 cycles. Load element k (k = i*4+j) with 32'h3f800000+k; pulse capture; hold out_ready=1.
  - Required: out_valid rises 1 cycle after capture. 16 consecutive beats with data 3f800000..3f80000f. out_row/out_col step 0,0 → 3,3. out_last only on beat 15. Then out_valid=0 and busy=0.
- Backpressure:
  - Stimulus: same load; out_ready toggles 1,0,0,1,…
  - Required: out_data, out_row and out_col are stable through every stalled cycle. No beat is duplicated or skipped. 16 transfers in total.
- Overrun:
  - Stimulus: capture a second matrix (all 32'h40000000) at beat 5 of the first.
  - Required: overrun=1 and stays 1. Remaining beats carry the first matrix's values. After beat 15, out_valid=0.
- Back-to-back:
  - Stimulus: capture a second matrix (r11=32'h3e9cdd17, r21=32'h3ee3e433, others 0) in the same cycle as beat 15's transfer.
  - Required: the next cycle presents 3e9cdd17 with row=0, col=0. overrun=0. 32 beats with no gap.
- Reset mid-stream:
  - Stimulus: assert rst at beat 7.
  - Required: the next cycle shows out_valid=0, busy=0, overrun=0 and idx=0. A following capture restarts cleanly from (0,0).
- Column-major build (LVG_DRAIN_COL_MAJOR_EN defined):
  - Stimulus: the row-major stream load.
  - Required: data order 3f800000, 3f800004, 3f800008, 3f80000c, 3f800001, … ending with 3f80000f flagged out_last.
